// File: rtl/sc_game_pkg.sv
// -----------------------------------------------------------------------------
// sc_game_pkg
// Shared definitions for the frogger game-flow sequencer:
//   - state_e    : FSM state encodings (also the debug STATE_OUT code)
//   - DEF_*      : default widths, lives, top level and respawn tick wait
// -----------------------------------------------------------------------------
package sc_game_pkg;

    localparam int DEF_DATAWIDTH_LIVES = 2;
    localparam int DEF_DATAWIDTH_LEVEL = 3;
    localparam int DEF_LIVES_INIT      = 3;
    localparam int DEF_LEVEL_MAX       = 7;
    localparam int DEF_WAIT_TICKS      = 16;

    // ST_PAUSED is never held in the state register; it is only shown on the
    // debug output while the pause overlay is active.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_INIT    = 3'b001,
        ST_SPAWN   = 3'b010,
        ST_PLAY    = 3'b011,
        ST_RESPAWN = 3'b100,
        ST_LEVELUP = 3'b101,
        ST_OVER    = 3'b110,
        ST_PAUSED  = 3'b111
    } state_e;

endpackage

// File: rtl/sc_game_tickwait.sv
// -----------------------------------------------------------------------------
// sc_game_tickwait
// Frame-tick counter used by the LEVELUP and RESPAWN waits.
//   clk_i    : clock
//   rst_n_i  : asynchronous reset, active-low
//   clear_i  : synchronous clear of the count (applied on wait-state entry)
//   en_i     : one-cycle tick qualified by the caller
//   done_o   : high on the tick that completes WAIT_TICKS ticks
// -----------------------------------------------------------------------------
module sc_game_tickwait
    import sc_game_pkg::*;
#(
    parameter int WAIT_TICKS = DEF_WAIT_TICKS
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear_i,
    input  logic en_i,
    output logic done_o
);

    localparam int CW = (WAIT_TICKS > 1) ? $clog2(WAIT_TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_TICKS - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign done_o = en_i && (cnt_q == LAST);

    // Wrap to zero on the terminal tick so a stale count never leaks into
    // the next wait, even if the caller does not clear.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = done_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sc_game_sequencer.sv
// -----------------------------------------------------------------------------
// sc_game_sequencer
// Round/level sequencer for frogger: owns game flow from power-up to game over.
// Optional build macro: SC_GAMESEQ_PAUSE_EN (adds SC_GAMESEQ_PAUSE_IN).
// Ports:
//   SC_GAMESEQ_CLOCK_50     : 50 MHz clock
//   SC_GAMESEQ_RESET        : asynchronous reset, active-low
//   SC_GAMESEQ_START_IN     : debounced start button (level)
//   SC_GAMESEQ_TICK_IN      : one-cycle frame tick
//   SC_GAMESEQ_GANO_IN      : win flag (level)
//   SC_GAMESEQ_PERDIO_IN    : loss flag (level)
//   SC_GAMESEQ_PAUSE_IN     : pause (level, only with SC_GAMESEQ_PAUSE_EN)
//   SC_GAMESEQ_CLEAR_OUT    : one-cycle clear to win counter / frog registers
//   SC_GAMESEQ_RANAINI_OUT  : one-cycle frog spawn strobe
//   SC_GAMESEQ_PLAY_OUT     : lane movement enable
//   SC_GAMESEQ_LIVES_OUT    : remaining lives
//   SC_GAMESEQ_LEVEL_OUT    : current level, 0-based
//   SC_GAMESEQ_GAMEOVER_OUT : high in OVER
//   SC_GAMESEQ_VICTORY_OUT  : high in OVER after winning the top level
//   SC_GAMESEQ_STATE_OUT    : encoded state for debug/display
// -----------------------------------------------------------------------------
module sc_game_sequencer
    import sc_game_pkg::*;
#(
    parameter int DATAWIDTH_LIVES = DEF_DATAWIDTH_LIVES,
    parameter int DATAWIDTH_LEVEL = DEF_DATAWIDTH_LEVEL,
    parameter int LIVES_INIT      = DEF_LIVES_INIT,
    parameter int LEVEL_MAX       = DEF_LEVEL_MAX,
    parameter int WAIT_TICKS      = DEF_WAIT_TICKS
) (
    input  logic                       SC_GAMESEQ_CLOCK_50,
    input  logic                       SC_GAMESEQ_RESET,
    input  logic                       SC_GAMESEQ_START_IN,
    input  logic                       SC_GAMESEQ_TICK_IN,
    input  logic                       SC_GAMESEQ_GANO_IN,
    input  logic                       SC_GAMESEQ_PERDIO_IN,
`ifdef SC_GAMESEQ_PAUSE_EN
    input  logic                       SC_GAMESEQ_PAUSE_IN,
`endif
    output logic                       SC_GAMESEQ_CLEAR_OUT,
    output logic                       SC_GAMESEQ_RANAINI_OUT,
    output logic                       SC_GAMESEQ_PLAY_OUT,
    output logic [DATAWIDTH_LIVES-1:0] SC_GAMESEQ_LIVES_OUT,
    output logic [DATAWIDTH_LEVEL-1:0] SC_GAMESEQ_LEVEL_OUT,
    output logic                       SC_GAMESEQ_GAMEOVER_OUT,
    output logic                       SC_GAMESEQ_VICTORY_OUT,
    output logic [2:0]                 SC_GAMESEQ_STATE_OUT
);

    if (LEVEL_MAX < 0 || LEVEL_MAX >= (1 << DATAWIDTH_LEVEL)) begin : g_bad_level_max
        $error("LEVEL_MAX must fit in DATAWIDTH_LEVEL bits");
    end
    if (LIVES_INIT < 1 || LIVES_INIT > (1 << DATAWIDTH_LIVES) - 1) begin : g_bad_lives_init
        $error("LIVES_INIT must be between 1 and 2^DATAWIDTH_LIVES-1");
    end
    if (WAIT_TICKS < 1) begin : g_bad_wait_ticks
        $error("WAIT_TICKS must be at least 1");
    end

    localparam logic [DATAWIDTH_LIVES-1:0] LIVES_LOAD = DATAWIDTH_LIVES'(LIVES_INIT);
    localparam logic [DATAWIDTH_LIVES-1:0] LIVES_ONE  = DATAWIDTH_LIVES'(1);
    localparam logic [DATAWIDTH_LEVEL-1:0] LVL_TOP    = DATAWIDTH_LEVEL'(LEVEL_MAX);

    state_e                     state_q, state_d;
    logic [DATAWIDTH_LIVES-1:0] lives_q, lives_d;
    logic [DATAWIDTH_LEVEL-1:0] level_q, level_d;
    logic                       victory_q, victory_d;
    logic                       start_low_q, start_low_d;  // START seen low while in OVER
    logic                       lvl_entry_q, lvl_entry_d;  // first cycle of LEVELUP
    logic                       paused;
    logic                       wait_clear, wait_en, wait_done;

`ifdef SC_GAMESEQ_PAUSE_EN
    assign paused = SC_GAMESEQ_PAUSE_IN && (state_q != ST_IDLE) && (state_q != ST_OVER);
`else
    assign paused = 1'b0;
`endif

    assign wait_en    = SC_GAMESEQ_TICK_IN && !paused &&
                        ((state_q == ST_LEVELUP) || (state_q == ST_RESPAWN));
    assign wait_clear = (state_q == ST_PLAY) &&
                        ((state_d == ST_LEVELUP) || (state_d == ST_RESPAWN));

    sc_game_tickwait #(
        .WAIT_TICKS (WAIT_TICKS)
    ) u_tickwait (
        .clk_i   (SC_GAMESEQ_CLOCK_50),
        .rst_n_i (SC_GAMESEQ_RESET),
        .clear_i (wait_clear),
        .en_i    (wait_en),
        .done_o  (wait_done)
    );

    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        level_d     = level_q;
        victory_d   = victory_q;
        // Restart requires a fresh press inside OVER, so a button held through
        // the losing frame cannot immediately start a new game.
        start_low_d = (state_q == ST_OVER) && (start_low_q || !SC_GAMESEQ_START_IN);
        lvl_entry_d = lvl_entry_q;
        if (!paused) begin
            case (state_q)
                ST_IDLE: begin
                    if (SC_GAMESEQ_START_IN) state_d = ST_INIT;
                end
                ST_INIT: begin
                    lives_d   = LIVES_LOAD;
                    level_d   = '0;
                    victory_d = 1'b0;
                    state_d   = ST_SPAWN;
                end
                ST_SPAWN: state_d = ST_PLAY;
                ST_PLAY: begin
                    // A win outranks a simultaneous loss; lives are untouched.
                    if (SC_GAMESEQ_GANO_IN) begin
                        if (level_q == LVL_TOP) begin
                            victory_d = 1'b1;
                            state_d   = ST_OVER;
                        end else begin
                            level_d = level_q + 1'b1;
                            state_d = ST_LEVELUP;
                        end
                    end else if (SC_GAMESEQ_PERDIO_IN) begin
                        if (lives_q <= LIVES_ONE) begin
                            lives_d = '0;
                            state_d = ST_OVER;
                        end else begin
                            lives_d = lives_q - 1'b1;
                            state_d = ST_RESPAWN;
                        end
                    end
                end
                ST_LEVELUP, ST_RESPAWN: begin
                    if (wait_done) state_d = ST_SPAWN;
                end
                ST_OVER: begin
                    if (SC_GAMESEQ_START_IN && start_low_q) state_d = ST_INIT;
                end
                default: state_d = ST_IDLE;
            endcase
            lvl_entry_d = (state_q == ST_PLAY) && (state_d == ST_LEVELUP);
        end
    end

    always_ff @(posedge SC_GAMESEQ_CLOCK_50 or negedge SC_GAMESEQ_RESET) begin
        if (!SC_GAMESEQ_RESET) begin
            state_q     <= ST_IDLE;
            lives_q     <= '0;
            level_q     <= '0;
            victory_q   <= 1'b0;
            start_low_q <= 1'b0;
            lvl_entry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            level_q     <= level_d;
            victory_q   <= victory_d;
            start_low_q <= start_low_d;
            lvl_entry_q <= lvl_entry_d;
        end
    end

    // Strobes are masked while paused so a frozen INIT/SPAWN/LEVELUP still
    // yields exactly one strobe cycle, on the cycle the freeze is lifted.
    assign SC_GAMESEQ_CLEAR_OUT    = !paused && ((state_q == ST_INIT) ||
                                                 ((state_q == ST_LEVELUP) && lvl_entry_q));
    assign SC_GAMESEQ_RANAINI_OUT  = !paused && (state_q == ST_SPAWN);
    assign SC_GAMESEQ_PLAY_OUT     = !paused && (state_q == ST_PLAY);
    assign SC_GAMESEQ_LIVES_OUT    = lives_q;
    assign SC_GAMESEQ_LEVEL_OUT    = level_q;
    assign SC_GAMESEQ_GAMEOVER_OUT = (state_q == ST_OVER);
    assign SC_GAMESEQ_VICTORY_OUT  = (state_q == ST_OVER) && victory_q;
    assign SC_GAMESEQ_STATE_OUT    = paused ? ST_PAUSED : state_q;

endmodule

// File: tb/tb_sc_game_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sc_game_sequencer
// Self-checking bench for sc_game_sequencer (default build, 3 lives, levels
// 0..7, 16-tick waits). A game-level model tracks phase, lives, level and the
// ticks still owed in a wait; every cycle the DUT outputs are compared to it.
// Directed scenarios pin model and DUT to hand-computed values, then a long
// randomized run with occasional asynchronous resets follows.
// -----------------------------------------------------------------------------
module tb_sc_game_sequencer;

    localparam logic [2:0] P_IDLE = 3'd0, P_INIT = 3'd1, P_SPAWN = 3'd2, P_PLAY = 3'd3,
                           P_RESP = 3'd4, P_LVUP = 3'd5, P_OVER = 3'd6;

    logic       clk = 1'b0;
    logic       rst_n, start, tick, gano, perdio;
    logic       clr_o, rana_o, play_o, over_o, vic_o;
    logic [1:0] lives_o;
    logic [2:0] level_o, state_o;

    always #10 clk = ~clk;

    sc_game_sequencer dut (
        .SC_GAMESEQ_CLOCK_50     (clk),
        .SC_GAMESEQ_RESET        (rst_n),
        .SC_GAMESEQ_START_IN     (start),
        .SC_GAMESEQ_TICK_IN      (tick),
        .SC_GAMESEQ_GANO_IN      (gano),
        .SC_GAMESEQ_PERDIO_IN    (perdio),
`ifdef SC_GAMESEQ_PAUSE_EN
        .SC_GAMESEQ_PAUSE_IN     (1'b0),
`endif
        .SC_GAMESEQ_CLEAR_OUT    (clr_o),
        .SC_GAMESEQ_RANAINI_OUT  (rana_o),
        .SC_GAMESEQ_PLAY_OUT     (play_o),
        .SC_GAMESEQ_LIVES_OUT    (lives_o),
        .SC_GAMESEQ_LEVEL_OUT    (level_o),
        .SC_GAMESEQ_GAMEOVER_OUT (over_o),
        .SC_GAMESEQ_VICTORY_OUT  (vic_o),
        .SC_GAMESEQ_STATE_OUT    (state_o)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Game-level model
    logic [2:0] m_ph;
    int         m_lives, m_level, m_ticks_left;
    bit         m_vic, m_armed, m_fresh;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = P_IDLE; m_lives = 0; m_level = 0; m_ticks_left = 0;
        m_vic = 0; m_armed = 0; m_fresh = 0;
    endtask

    // One clock of game rules applied to the inputs held over that edge.
    task automatic model_step();
        bit fresh;
        fresh = 0;
        case (m_ph)
            P_IDLE:  if (start) m_ph = P_INIT;
            P_INIT:  begin m_lives = 3; m_level = 0; m_vic = 0; m_ph = P_SPAWN; end
            P_SPAWN: m_ph = P_PLAY;
            P_PLAY: begin
                if (gano) begin
                    if (m_level == 7) begin
                        m_vic = 1; m_ph = P_OVER; m_armed = 0;
                    end else begin
                        m_level++; m_ph = P_LVUP; m_ticks_left = 16; fresh = 1;
                    end
                end else if (perdio) begin
                    m_lives--;
                    if (m_lives == 0) begin
                        m_ph = P_OVER; m_armed = 0;
                    end else begin
                        m_ph = P_RESP; m_ticks_left = 16;
                    end
                end
            end
            P_RESP, P_LVUP: begin
                if (tick) begin
                    m_ticks_left--;
                    if (m_ticks_left == 0) m_ph = P_SPAWN;
                end
            end
            P_OVER: begin
                if (start && m_armed) begin
                    m_ph = P_INIT; m_armed = 0;
                end else if (!start) begin
                    m_armed = 1;
                end
            end
            default: m_ph = P_IDLE;
        endcase
        m_fresh = fresh;
    endtask

    task automatic compare_all();
        chk("state",    int'(state_o), int'(m_ph));
        chk("clear",    int'(clr_o),   int'((m_ph == P_INIT) || (m_ph == P_LVUP && m_fresh)));
        chk("ranaini",  int'(rana_o),  int'(m_ph == P_SPAWN));
        chk("play",     int'(play_o),  int'(m_ph == P_PLAY));
        chk("lives",    int'(lives_o), m_lives);
        chk("level",    int'(level_o), m_level);
        chk("gameover", int'(over_o),  int'(m_ph == P_OVER));
        chk("victory",  int'(vic_o),   int'(m_ph == P_OVER && m_vic));
    endtask

    // Called at a falling edge: drive inputs, let one rising edge pass, then
    // check outputs at the next falling edge.
    task automatic step(input bit st, input bit tk, input bit g, input bit p);
        start = st; tick = tk; gano = g; perdio = p;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        chk("rst_state", int'(state_o), 0);
        chk("rst_lives", int'(lives_o), 0);
        chk("rst_strobes", int'({clr_o, rana_o, play_o}), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int mode, pg, pp;
        rst_n = 1'b1; start = 0; tick = 0; gano = 0; perdio = 0;
        model_reset();
        #5;
        do_reset();

        // Start: IDLE -> INIT -> SPAWN -> PLAY
        step(1, 0, 0, 0);
        chk("t1_init_state", int'(state_o), 1);
        chk("t1_init_clear", int'(clr_o), 1);
        chk("t1_model_clear", int'(m_ph == P_INIT), 1);
        step(0, 0, 0, 0);
        chk("t1_spawn_rana", int'(rana_o), 1);
        chk("t1_lives", int'(lives_o), 3);
        chk("t1_model_lives", m_lives, 3);
        step(0, 0, 0, 0);
        chk("t1_play", int'(play_o), 1);

        // Loss -> RESPAWN, 16 ticks, respawn
        step(0, 0, 0, 1);
        chk("t2_resp_state", int'(state_o), 4);
        chk("t2_lives", int'(lives_o), 2);
        ticks(15);
        chk("t2_still_wait", int'(state_o), 4);
        chk("t2_model_wait", int'(m_ph), 4);
        ticks(1);
        chk("t2_spawn_rana", int'(rana_o), 1);
        step(0, 0, 0, 0);

        // Second loss -> lives 1
        step(0, 0, 0, 1);
        ticks(16);
        step(0, 0, 0, 0);
        chk("t3_lives1", int'(lives_o), 1);

        // Win and loss together with one life left: level up, no game over
        step(0, 0, 1, 1);
        chk("t5_state", int'(state_o), 5);
        chk("t5_lives", int'(lives_o), 1);
        chk("t5_clear", int'(clr_o), 1);
        chk("t5_over", int'(over_o), 0);
        step(0, 0, 0, 0);
        chk("t5_clear_once", int'(clr_o), 0);
        ticks(16);
        step(0, 0, 0, 0);

        // Final loss -> OVER, held START ignored, fresh press restarts
        step(1, 0, 0, 1);
        chk("t3_over", int'(over_o), 1);
        chk("t3_lives0", int'(lives_o), 0);
        chk("t3_novictory", int'(vic_o), 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        chk("t3_held_start", int'(state_o), 6);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("t3_restart", int'(state_o), 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Climb all levels, then victory
        for (int lv = 0; lv < 7; lv++) begin
            step(0, 0, 1, 0);
            chk("t4_level", int'(level_o), lv + 1);
            chk("t4_clear", int'(clr_o), 1);
            step(0, 0, 0, 0);
            ticks(16);
            step(0, 0, 0, 0);
        end
        step(0, 0, 1, 0);
        chk("t4_victory", int'(vic_o), 1);
        chk("t4_level7", int'(level_o), 7);
        chk("t4_model_vic", int'(m_vic), 1);

        // Reset in the middle of a respawn wait
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        ticks(5);
        do_reset();
        step(0, 1, 0, 0);
        chk("t6_idle_after", int'(state_o), 0);

        // Randomized play
        mode = 0; pg = 8; pp = 4;
        for (int c = 0; c < 24000; c++) begin
            if (c % 500 == 0) begin
                mode = int'($urandom_range(0, 2));
                pg = (mode == 0) ? 8 : (mode == 1) ? 10 : 0;
                pp = (mode == 0) ? 4 : (mode == 1) ? 0 : 8;
            end
            if ($urandom_range(0, 3999) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 99) < 30,
                     $urandom_range(0, 1) == 1,
                     $urandom_range(0, 99) < pg,
                     $urandom_range(0, 99) < pp);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sc_game_sequencer.md
Name: sc_game_sequencer

Overview:
Round/level sequencer for the frogger game. It sits above the frog win counter and the frog/lane datapath. It consumes the win flag (GANO) and the loss flag (PERDIO), and drives the frog-spawn strobe, the clear strobe for counters and frogs, lives, level, and lane-speed selection. It is the single owner of game flow from power-up through game over.

Parameters:
DATAWIDTH_LIVES, 2, width of lives counter
DATAWIDTH_LEVEL, 3, width of level counter
LIVES_INIT, 3, lives loaded at game start
LEVEL_MAX, 7, highest level; win at LEVEL_MAX ends the game as victory
WAIT_TICKS, 16, frame ticks held in RESPAWN and LEVELUP states (>=1)

Ports:
SC_GAMESEQ_CLOCK_50  in  1  system clock, 50 MHz
SC_GAMESEQ_RESET  in  1  asynchronous reset, active-low
SC_GAMESEQ_START_IN  in  1  start button, already debounced, level
SC_GAMESEQ_TICK_IN  in  1  one-cycle frame tick
SC_GAMESEQ_GANO_IN  in  1  win flag from frog win counter (level)
SC_GAMESEQ_PERDIO_IN  in  1  frog collision/loss flag (level)
SC_GAMESEQ_CLEAR_OUT  out  1  one-cycle clear to win counter and frog registers
SC_GAMESEQ_RANAINI_OUT  out  1  one-cycle frog spawn strobe
SC_GAMESEQ_PLAY_OUT  out  1  high while in PLAY (enables lane movement)
SC_GAMESEQ_LIVES_OUT  out  DATAWIDTH_LIVES  remaining lives
SC_GAMESEQ_LEVEL_OUT  out  DATAWIDTH_LEVEL  current level, 0-based
SC_GAMESEQ_GAMEOVER_OUT  out  1  high in OVER state
SC_GAMESEQ_VICTORY_OUT  out  1  high in OVER when the game ended by winning LEVEL_MAX
SC_GAMESEQ_STATE_OUT  out  3  encoded state for debug/display

Behaviour:
- Reset (SC_GAMESEQ_RESET=0, async): state=IDLE, lives=0, level=0, wait counter=0, victory=0. All strobes are 0.
- States and encodings: IDLE=000, INIT=001, SPAWN=010, PLAY=011, RESPAWN=100, LEVELUP=101, OVER=110.
- The state register and counters are registered. Outputs decode from registered state as Moore outputs. Strobes are high for exactly the one cycle the FSM spends in their state.
- IDLE: when START_IN=1, go to INIT on the next clock.
- INIT (1 cycle):
  - CLEAR_OUT=1.
  - lives<=LIVES_INIT, level<=0, victory<=0.
  - Go to SPAWN.
- SPAWN (1 cycle): RANAINI_OUT=1, then go to PLAY.
- PLAY: PLAY_OUT=1. Priority order, evaluated each cycle:
  1. GANO_IN=1:
     - If level==LEVEL_MAX: victory<=1, go to OVER.
     - Otherwise: level<=level+1, go to LEVELUP.
  2. PERDIO_IN=1:
     - If lives==1: lives<=0, go to OVER.
     - Otherwise: lives<=lives-1, go to RESPAWN.
  3. Otherwise stay in PLAY.
- Simultaneous GANO and PERDIO: GANO wins; lives are unchanged.
- LEVELUP:
  - On entry, wait counter<=0 and CLEAR_OUT=1 for the entry cycle only.
  - Count TICK_IN pulses; when the count reaches WAIT_TICKS-1 and TICK_IN=1, go to SPAWN.
- RESPAWN:
  - Same tick wait as LEVELUP, but with no CLEAR_OUT; the win counter keeps its progress.
  - Then go to SPAWN.
- OVER:
  - GAMEOVER_OUT=1; VICTORY_OUT=victory.
  - Stay until START_IN is observed 0 and then 1 (rising edge, internal 1-bit history). Then go to INIT.
  - This prevents a held start button from auto-restarting.
- Level saturates at LEVEL_MAX and never wraps. Lives never underflow; decrement happens only when lives>=2.
- LEVEL_MAX must be < 2^DATAWIDTH_LEVEL, and LIVES_INIT must be between 1 and 2^DATAWIDTH_LIVES-1. Both are checked by a generate-time error.
- TICK_IN outside LEVELUP/RESPAWN is ignored.
- Async reset mid-operation: immediate return to reset values. No strobe is produced until the next INIT.

Optional Feature:
SC_GAMESEQ_PAUSE_EN:
- Defined:
  - Adds input SC_GAMESEQ_PAUSE_IN (level).
  - PAUSE_IN=1 forces PLAY_OUT=0 and freezes the FSM and wait counter in any state except IDLE/OVER; GANO/PERDIO are ignored while paused.
  - Adds STATE_OUT encoding 111 (PAUSED overlay) while paused.
- Undefined: no pause port; behaviour exactly as above.

Decomposition:
- Shared package/include `sc_game_pkg`:
  - state encodings (IDLE..OVER, PAUSED)
  - default LIVES_INIT, LEVEL_MAX, WAIT_TICKS
  - DATAWIDTH_LIVES/LEVEL
- One sub-module: `sc_game_tickwait`, a loadable tick counter with clear, enable, and `done` (asserted on the terminal tick). It is shared by LEVELUP and RESPAWN.
- The FSM and the lives/level registers stay in the top module.

Test Plan:
1. Reset low, release, START=1 -> state IDLE→INIT→SPAWN→PLAY over 3 clocks. CLEAR_OUT=1 in cycle 2, RANAINI_OUT=1 in cycle 3, lives=3, level=0.
2. In PLAY, pulse PERDIO -> lives=2, RESPAWN. After 16 TICK_IN pulses -> SPAWN (RANAINI=1), then PLAY. CLEAR_OUT stays 0 throughout.
3. PERDIO three times -> third loss gives lives=0, GAMEOVER_OUT=1, VICTORY_OUT=0. With START held at 1, state stays OVER. START 0→1 -> INIT.
4. GANO in PLAY at level 0 -> level=1, CLEAR_OUT=1 one cycle, 16 ticks, respawn. Repeat to level 7, then GANO -> OVER, VICTORY_OUT=1, level stays 7.
5. GANO and PERDIO asserted in the same cycle with lives=1 -> LEVELUP, lives remain 1, no GAMEOVER.
6. Assert reset mid-RESPAWN at tick 5 -> outputs return to reset values immediately. With PAUSE_EN defined, PAUSE_IN=1 in RESPAWN freezes the tick count across 10 ticks.
